// File: rtl/cpu_pkg.sv
// Shared core constants: GPR file geometry and scoreboard counter sizing.
// Latency: n/a (constants only).
// Backpressure: n/a.
package cpu_pkg;

  // GPR address width (32 registers)
  localparam int GPR_AW = 5;
  // Per-register pending-write counter width
  localparam int SB_CNT_W = 2;
  // Hard-wired zero register; writes to it are never tracked
  localparam logic [4:0] GPR_ZERO = 5'd0;

endpackage

// File: rtl/sb_counter.sv
// One pending-write counter for a single GPR: +1 on issue, -1 on commit, clear on flush.
// Latency: count updates on the next clk edge; at_max/nz are straight from the register.
// Backpressure: none internally; the caller must not raise inc while at_max is high.
//
// Ports:
//   clk, reset   core clock, async active-high reset
//   inc, dec     issue / commit of a write to this register (both -> no change)
//   clr          flush; wins over inc/dec
//   at_max, nz   counter saturated / counter non-zero
module sb_counter #(
  parameter int CNT_W = 2
) (
  input  logic clk,
  input  logic reset,
  input  logic inc,
  input  logic dec,
  input  logic clr,
  output logic at_max,
  output logic nz
);

  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clr) begin
      cnt_d = '0;
    end else if (inc && !dec && (cnt_q != CNT_MAX)) begin
      cnt_d = cnt_q + CNT_W'(1);
    end else if (dec && !inc && (cnt_q != '0)) begin
      // A commit with nothing pending (stale WB after a flush) is dropped.
      cnt_d = cnt_q - CNT_W'(1);
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign at_max = (cnt_q == CNT_MAX);
  assign nz     = (cnt_q != '0);

`ifndef SYNTHESIS
  // Decrement from zero is dropped by the logic above; make it visible in sim.
  always @(posedge clk) begin
    if (!reset && !clr && dec && !inc && !nz) begin
      $warning("sb_counter: commit to register with no pending write ignored");
    end
  end
`endif

endmodule

// File: rtl/reg_hazard_scoreboard.sv
// Pending-write scoreboard between ID issue and WB commit; stalls ID on RAW and WAW-overflow hazards.
// Latency: outputs are combinational from inputs and registered counters; a commit clears its stall one cycle later.
// Backpressure: id_allow_in drops while a valid ID instruction is stalled or EX cannot accept.
//
// Ports:
//   clk, reset                              core clock, async active-high reset
//   id_valid, id_rs1/_en, id_rs2/_en,
//   id_rd, id_rd_we                         decoded instruction in ID
//   ex_allow_in                             ID/EX register can accept
//   flush                                   redirect; drops every tracked write
//   wb_rd, wb_we                            WB register write port
//   id_ready_go, id_to_ex_valid,
//   id_allow_in                             ID handshake outputs
//   sb_busy                                 some write is still in flight
module reg_hazard_scoreboard
  import cpu_pkg::*;
#(
  parameter int REG_AW = GPR_AW,
  parameter int CNT_W  = SB_CNT_W
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              id_valid,
  input  logic [REG_AW-1:0] id_rs1,
  input  logic              id_rs1_en,
  input  logic [REG_AW-1:0] id_rs2,
  input  logic              id_rs2_en,
  input  logic [REG_AW-1:0] id_rd,
  input  logic              id_rd_we,
  input  logic              ex_allow_in,
  input  logic              flush,
  input  logic [REG_AW-1:0] wb_rd,
  input  logic              wb_we,
  output logic              id_ready_go,
  output logic              id_to_ex_valid,
  output logic              id_allow_in,
  output logic              sb_busy
);

  localparam int NREG = 2 ** REG_AW;
  localparam logic [REG_AW-1:0] ZERO_REG = REG_AW'(GPR_ZERO);

  logic [NREG-1:0] nz;
  logic [NREG-1:0] at_max;
  logic            haz;
  logic            issue;
  logic            commit;

  // x0 is never written, so it never has a pending write.
  assign nz[0]     = 1'b0;
  assign at_max[0] = 1'b0;

  // Sources wait for every pending write; a destination only waits when its
  // counter has no room for another in-flight write. The commit happening this
  // cycle is deliberately not bypassed: the regfile is not write-first.
  assign haz = (id_rs1_en & nz[id_rs1])
             | (id_rs2_en & nz[id_rs2])
             | (id_rd_we  & at_max[id_rd]);

  assign id_ready_go    = ~haz;
  assign id_to_ex_valid = id_valid & id_ready_go & ~flush;
  assign id_allow_in    = ~id_valid | (id_ready_go & ex_allow_in);

  assign issue  = id_valid & id_ready_go & ex_allow_in & ~flush & id_rd_we & (id_rd != ZERO_REG);
  assign commit = wb_we & (wb_rd != ZERO_REG);

  for (genvar r = 1; r < NREG; r++) begin : g_cnt
    sb_counter #(
      .CNT_W (CNT_W)
    ) u_cnt (
      .clk    (clk),
      .reset  (reset),
      .inc    (issue  && (id_rd == REG_AW'(r))),
      .dec    (commit && (wb_rd == REG_AW'(r))),
      .clr    (flush),
      .at_max (at_max[r]),
      .nz     (nz[r])
    );
  end

  assign sb_busy = |nz;

endmodule

// File: tb/tb_reg_hazard_scoreboard.sv
module tb_reg_hazard_scoreboard;

  localparam int MAXC = 3;

  logic       clk = 1'b0;
  logic       reset;
  logic       id_valid;
  logic [4:0] id_rs1;
  logic       id_rs1_en;
  logic [4:0] id_rs2;
  logic       id_rs2_en;
  logic [4:0] id_rd;
  logic       id_rd_we;
  logic       ex_allow_in;
  logic       flush;
  logic [4:0] wb_rd;
  logic       wb_we;
  logic       id_ready_go;
  logic       id_to_ex_valid;
  logic       id_allow_in;
  logic       sb_busy;

  int checks = 0;
  int fails  = 0;
  int m_cnt [32];

  reg_hazard_scoreboard dut (
    .clk            (clk),
    .reset          (reset),
    .id_valid       (id_valid),
    .id_rs1         (id_rs1),
    .id_rs1_en      (id_rs1_en),
    .id_rs2         (id_rs2),
    .id_rs2_en      (id_rs2_en),
    .id_rd          (id_rd),
    .id_rd_we       (id_rd_we),
    .ex_allow_in    (ex_allow_in),
    .flush          (flush),
    .wb_rd          (wb_rd),
    .wb_we          (wb_we),
    .id_ready_go    (id_ready_go),
    .id_to_ex_valid (id_to_ex_valid),
    .id_allow_in    (id_allow_in),
    .sb_busy        (sb_busy)
  );

  always #5 clk = ~clk;

  // Reference model: number of writes in flight per register.
  function automatic bit m_haz();
    return (id_rs1_en && m_cnt[id_rs1] != 0) ||
           (id_rs2_en && m_cnt[id_rs2] != 0) ||
           (id_rd_we  && m_cnt[id_rd] >= MAXC);
  endfunction

  function automatic bit m_busy();
    for (int i = 0; i < 32; i++) if (m_cnt[i] != 0) return 1'b1;
    return 1'b0;
  endfunction

  initial for (int i = 0; i < 32; i++) m_cnt[i] = 0;

  always @(posedge clk or posedge reset) begin : model
    bit iss;
    bit cmt;
    if (reset || flush) begin
      for (int i = 0; i < 32; i++) m_cnt[i] = 0;
    end else begin
      iss = id_valid && !m_haz() && ex_allow_in && id_rd_we && (id_rd != 0);
      cmt = wb_we && (wb_rd != 0);
      if (iss && cmt && id_rd == wb_rd) begin
        // issue and commit to the same register cancel
      end else begin
        if (iss) m_cnt[id_rd] = m_cnt[id_rd] + 1;
        if (cmt && m_cnt[wb_rd] > 0) m_cnt[wb_rd] = m_cnt[wb_rd] - 1;
      end
    end
  end

  task automatic chk(input string name, input logic act, input logic exp);
    checks++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %b expected %b at %0t", name, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin : compare
    bit e_rdy;
    e_rdy = !m_haz();
    chk("cmp_ready_go", id_ready_go, e_rdy);
    chk("cmp_to_ex_valid", id_to_ex_valid, id_valid && e_rdy && !flush);
    chk("cmp_allow_in", id_allow_in, !id_valid || (e_rdy && ex_allow_in));
    chk("cmp_busy", sb_busy, m_busy());
  end

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic settle();
    #2;
  endtask

  task automatic drv(input logic v, input logic [4:0] rs1, input logic e1,
                     input logic [4:0] rs2, input logic e2,
                     input logic [4:0] rd, input logic we);
    id_valid = v; id_rs1 = rs1; id_rs1_en = e1;
    id_rs2 = rs2; id_rs2_en = e2; id_rd = rd; id_rd_we = we;
  endtask

  task automatic wb(input logic [4:0] rd, input logic we);
    wb_rd = rd; wb_we = we;
  endtask

  task automatic idle();
    drv(0, 0, 0, 0, 0, 0, 0);
  endtask

  initial begin
    reset = 1'b0; flush = 1'b0; ex_allow_in = 1'b1;
    idle(); wb(0, 0);

    // 1. reset, then idle
    #1 reset = 1'b1;
    settle();
    chk("rst_busy", sb_busy, 1'b0);
    chk("rst_ready", id_ready_go, 1'b1);
    #9 reset = 1'b0;
    #1 chk("rst_allow_in", id_allow_in, 1'b1);

    // 2. RAW stall on x2, cleared one cycle after commit
    cyc(); drv(1, 0, 0, 0, 0, 2, 1); settle();
    chk("raw_issue_ready", id_ready_go, 1'b1);
    cyc(); drv(1, 2, 1, 0, 0, 0, 0); settle();
    chk("raw_stall", id_ready_go, 1'b0);
    chk("raw_allow_in", id_allow_in, 1'b0);
    cyc(); wb(2, 1); settle();
    chk("raw_commit_cycle", id_ready_go, 1'b0);
    cyc(); wb(0, 0); settle();
    chk("raw_released", id_ready_go, 1'b1);
    chk("raw_to_ex", id_to_ex_valid, 1'b1);

    // 3. same-cycle issue + commit on x5
    cyc(); drv(1, 0, 0, 0, 0, 5, 1);
    cyc(); wb(5, 1); settle();
    chk("x5_second_writer", id_ready_go, 1'b1);
    cyc(); wb(0, 0); drv(1, 0, 0, 5, 1, 0, 0); settle();
    chk("x5_reader_stall", id_ready_go, 1'b0);
    chk("x5_busy", sb_busy, 1'b1);
    cyc(); wb(5, 1); settle();
    chk("x5_commit_cycle", id_ready_go, 1'b0);
    cyc(); wb(0, 0); settle();
    chk("x5_released", id_ready_go, 1'b1);
    chk("x5_drained", sb_busy, 1'b0);

    // 4. WAW saturation on x3
    cyc(); drv(1, 0, 0, 0, 0, 3, 1); settle();
    chk("waw_w1", id_ready_go, 1'b1);
    cyc(); settle(); chk("waw_w2", id_ready_go, 1'b1);
    cyc(); settle(); chk("waw_w3", id_ready_go, 1'b1);
    cyc(); settle(); chk("waw_w4_stall", id_ready_go, 1'b0);
    cyc(); wb(3, 1); settle();
    chk("waw_commit_cycle", id_ready_go, 1'b0);
    cyc(); wb(0, 0); settle();
    chk("waw_w4_go", id_ready_go, 1'b1);
    cyc(); idle(); wb(3, 1);
    cyc(); cyc(); cyc(); wb(0, 0); settle();
    chk("waw_drained", sb_busy, 1'b0);

    // 5. x0 writes and back-pressure
    drv(1, 0, 0, 0, 0, 0, 1);
    cyc(); settle();
    chk("x0_not_busy", sb_busy, 1'b0);
    ex_allow_in = 1'b0; drv(1, 0, 0, 0, 0, 6, 1); settle();
    chk("bp_allow_in", id_allow_in, 1'b0);
    chk("bp_ready", id_ready_go, 1'b1);
    cyc(); settle();
    chk("bp_not_counted", sb_busy, 1'b0);
    ex_allow_in = 1'b1; idle();

    // 6. flush and async reset mid-operation
    cyc(); drv(1, 0, 0, 0, 0, 1, 1);
    cyc(); drv(1, 0, 0, 0, 0, 4, 1);
    cyc(); idle(); settle();
    chk("fl_pending", sb_busy, 1'b1);
    flush = 1'b1; drv(1, 0, 0, 0, 0, 7, 1); settle();
    chk("fl_to_ex", id_to_ex_valid, 1'b0);
    cyc(); flush = 1'b0; idle(); settle();
    chk("fl_cleared", sb_busy, 1'b0);
    wb(1, 1);
    cyc(); wb(0, 0); drv(1, 1, 1, 0, 0, 0, 0); settle();
    chk("fl_stale_wb_ignored", sb_busy, 1'b0);
    chk("fl_reader_x1", id_ready_go, 1'b1);
    drv(1, 0, 0, 0, 0, 9, 1);
    cyc(); idle(); settle();
    chk("ar_pending", sb_busy, 1'b1);
    reset = 1'b1;
    #1 chk("ar_async_clear", sb_busy, 1'b0);
    chk("ar_ready", id_ready_go, 1'b1);
    cyc(); reset = 1'b0; settle();
    chk("ar_after_release", sb_busy, 1'b0);

    cyc(); cyc();
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule
